// File: rtl/led_scan_capture.sv
// led_scan_capture
//   Receive side of the LED-matrix scanner. Watches the (x, y) lit-point
//   stream, rebuilds whole ROWS x COLS frames in a double-buffered register
//   store, and presents the last complete frame on a registered row-read
//   port together with a frame-done pulse, a frame counter and a sticky
//   row-skip flag.
//
//   Frame boundaries are detected from the scan order itself. The generator
//   walks y downward, so any accepted point whose row is above the previous
//   point's row (a "wrap") starts a new frame. After enabling, the block first
//   hunts for a wrap (SYNC) so that the partial frame in flight is never
//   shown; from then on every wrap commits the frame just built.

module led_scan_capture #(
  parameter int COLS  = 8,
  parameter int ROWS  = 16,
  parameter int CNT_W = 8
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      cap_en,
  input  logic                      pt_valid,
  input  logic [$clog2(COLS)-1:0]   x_in,
  input  logic [$clog2(ROWS)-1:0]   y_in,
  input  logic [$clog2(ROWS)-1:0]   rd_y,
  output logic [COLS-1:0]           rd_row,
  output logic                      frame_done,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic                      seq_err
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q;
  logic              wsel_q;        // bank currently being written
  logic [YW-1:0]     last_y_q;      // row of the most recent accepted point
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              frame_done_q;
  logic              seq_err_q;
  logic [COLS-1:0]   rd_row_q;

  // Two frame banks; bank wsel_q is written, bank ~wsel_q is displayed.
  logic [COLS-1:0]   bank_q [2][ROWS];

  // ---------------------------------------------------------------------
  // Point decode
  // ---------------------------------------------------------------------
  logic              accept;        // point is seen by the capture logic
  logic              wrap;          // accepted point starts a new frame
  logic              commit;        // wrap while capturing: publish frame
  logic              lock;          // wrap while syncing: start first frame
  logic              store;         // point is written into a bank
  logic              skip;          // a row was jumped over inside a frame
  logic              wsel_d;        // write bank after this edge
  logic [COLS-1:0]   pt_mask;       // one-hot column of the current point

  // Classify the current strobe against the scan order and the FSM state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    accept  = 1'b0;
    wrap    = 1'b0;
    commit  = 1'b0;
    lock    = 1'b0;
    store   = 1'b0;
    skip    = 1'b0;
    pt_mask = '0;

    if (pt_valid && cap_en && (state_q != IDLE)) begin
      accept  = 1'b1;
      wrap    = (y_in > last_y_q);
      pt_mask = COLS'(1) << x_in;

      if (state_q == CAPTURE) begin
        store  = 1'b1;
        commit = wrap;
        // Non-wrap means y_in <= last_y_q, so the difference is non-negative.
        skip   = !wrap && ((last_y_q - y_in) > YW'(1));
      end else begin
        lock   = wrap;
        store  = wrap;
      end
    end

    wsel_d = wsel_q ^ commit;
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered status outputs
  // ---------------------------------------------------------------------

  // Sequence IDLE/SYNC/CAPTURE, swap banks on commit, track status flags.
  always_ff @(posedge CLK or negedge RSTn) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!RSTn) begin
      state_q      <= IDLE;
      wsel_q       <= 1'b0;
      last_y_q     <= YW'(ROWS - 1);
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      frame_done_q <= commit;
      wsel_q       <= wsel_d;

      if (accept) begin
        last_y_q <= y_in;
      end

      if (commit) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end

      if (skip) begin
        seq_err_q <= 1'b1;
      end

      if (!cap_en) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE:    state_q <= SYNC;
          SYNC:    if (lock) state_q <= CAPTURE;
          CAPTURE: state_q <= CAPTURE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame store
  // ---------------------------------------------------------------------

  // Write the point into the write bank; a wrap first clears that bank so
  // the wrap point becomes the first point of the new frame.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: the banks are reset explicitly because a blank display after
      // reset is part of the block's behaviour; this rules out RAM inference,
      // which is acceptable for a store this small.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else if (store) begin
      for (int r = 0; r < ROWS; r++) begin
        bank_q[wsel_d][r] <= (wrap ? '0 : bank_q[wsel_d][r]) |
                             ((YW'(r) == y_in) ? pt_mask : '0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------

  // Registered row read from the display bank, using the pre-edge bank select.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_row_q <= '0;
    end else begin
      rd_row_q <= bank_q[~wsel_q][rd_y];
    end
  end

  assign rd_row     = rd_row_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_led_scan_capture.sv
// tb_led_scan_capture
//   Drives directed and randomized scan streams into led_scan_capture and
//   compares every output, every cycle, against a frame-level model: the
//   model keeps "frame being built" and "last complete frame" as plain arrays
//   and applies the wrap / sync / enable rules directly.

module tb_led_scan_capture;

  logic       CLK      = 1'b0;
  logic       RSTn     = 1'b0;
  logic       cap_en   = 1'b0;
  logic       pt_valid = 1'b0;
  logic [2:0] x_in     = '0;
  logic [3:0] y_in     = '0;
  logic [3:0] rd_y     = '0;
  logic [7:0] rd_row;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  led_scan_capture #(.COLS(8), .ROWS(16), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .cap_en    (cap_en),
    .pt_valid  (pt_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .rd_y      (rd_y),
    .rd_row    (rd_row),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .seq_err   (seq_err)
  );

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Frame-level reference model
  // -------------------------------------------------------------------
  localparam int M_OFF  = 0;   // capture disabled
  localparam int M_HUNT = 1;   // waiting for the first frame boundary
  localparam int M_LIVE = 2;   // assembling frames

  int m_mode   = M_OFF;
  int m_last_y = 15;
  int m_cnt    = 0;
  int m_err    = 0;
  int m_build [16];            // frame being assembled
  int m_shown [16];            // last complete frame
  int exp_rd   = 0;
  int exp_done = 0;
  int exp_cnt  = 0;
  int exp_err  = 0;
  bit chk_on   = 1'b0;

  initial begin
    foreach (m_build[i]) begin
      m_build[i] = 0;
      m_shown[i] = 0;
    end
  end

  initial forever begin
    @(posedge CLK or negedge RSTn);
    if (!RSTn) begin
      m_mode   = M_OFF;
      m_last_y = 15;
      m_cnt    = 0;
      m_err    = 0;
      foreach (m_build[i]) begin
        m_build[i] = 0;
        m_shown[i] = 0;
      end
      exp_rd   = 0;
      exp_done = 0;
      exp_cnt  = 0;
      exp_err  = 0;
    end else begin
      int px, py, done_n;
      px     = int'(x_in);
      py     = int'(y_in);
      done_n = 0;
      exp_rd = m_shown[int'(rd_y)];
      if (!cap_en) begin
        m_mode = M_OFF;
      end else if (m_mode == M_OFF) begin
        m_mode = M_HUNT;
      end else if (pt_valid) begin
        if (py > m_last_y) begin
          if (m_mode == M_LIVE) begin
            foreach (m_shown[i]) m_shown[i] = m_build[i];
            m_cnt  = (m_cnt + 1) % 256;
            done_n = 1;
          end
          foreach (m_build[i]) m_build[i] = 0;
          m_build[py] = 1 << px;
          m_mode = M_LIVE;
        end else if (m_mode == M_LIVE) begin
          if (m_last_y - py > 1) m_err = 1;
          m_build[py] = m_build[py] | (1 << px);
        end
        m_last_y = py;
      end
      exp_done = done_n;
      exp_cnt  = m_cnt;
      exp_err  = m_err;
    end
  end

  // One compare process, away from the active edge.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("rd_row",     int'(rd_row),     exp_rd);
      check("frame_done", int'(frame_done), exp_done);
      check("frame_cnt",  int'(frame_cnt),  exp_cnt);
      check("seq_err",    int'(seq_err),    exp_err);
    end
  end

  // -------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at the next one)
  // -------------------------------------------------------------------
  task automatic step(bit v, int x, int y);
    pt_valid = v;
    x_in     = 3'(x);
    y_in     = 4'(y);
    @(negedge CLK);
  endtask

  task automatic rstep(bit v, int x, int y);
    rd_y = 4'($urandom_range(0, 15));
    step(v, x, y);
  endtask

  task automatic read_row(int r, output int v);
    rd_y = 4'(r);
    step(1'b0, 0, 0);
    v = int'(rd_row);
  endtask

  task automatic drop_burst();
    cap_en = 1'b0;
    repeat ($urandom_range(2, 6))
      rstep(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15));
    cap_en = 1'b1;
  endtask

  // One descending scan from row 'top' to row 0, 1..2 points per row.
  task automatic scan(int top, bit allow_drop);
    int k;
    for (int y = top; y >= 0; y--) begin
      k = $urandom_range(1, 2);
      for (int i = 0; i < k; i++) begin
        repeat ($urandom_range(0, 2)) rstep(1'b0, 0, 0);
        rstep(1'b1, $urandom_range(0, 7), y);
        if (allow_drop && ($urandom_range(0, 59) == 0)) drop_burst();
      end
    end
  endtask

  // -------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------
  initial begin
    int v, top, wy;
    int snap [16];

    // Reset and blank read-back.
    repeat (3) @(negedge CLK);
    RSTn   = 1'b1;
    chk_on = 1'b1;
    for (int r = 0; r < 16; r++) begin
      read_row(r, v);
      check("reset_row", v, 8'h00);
    end
    check("reset_cnt", int'(frame_cnt), 0);

    // Sync discard: partial frame then the first wrap.
    cap_en = 1'b1;
    step(1'b0, 0, 0);
    for (int y = 7; y >= 0; y--) step(1'b1, y, y);
    step(1'b1, 1, 15);
    check("sync_done", int'(frame_done), 0);
    step(1'b0, 0, 0);
    check("sync_cnt", int'(frame_cnt), 0);
    for (int r = 0; r < 16; r++) begin
      read_row(r, v);
      check("sync_row", v, 8'h00);
    end

    // Full frame with known pattern, swap timing on row 15.
    step(1'b1, 0, 15);
    step(1'b1, 1, 15);
    for (int y = 14; y >= 0; y--) begin
      step(1'b1, (4 * (15 - y)) % 8, y);
      step(1'b1, (4 * (15 - y)) % 8 + 1, y);
    end
    rd_y = 4'd15;
    step(1'b1, 2, 15);
    check("swap_old_row", int'(rd_row), 8'h00);
    check("commit_done",  int'(frame_done), 1);
    check("commit_cnt",   int'(frame_cnt), 1);
    step(1'b0, 0, 0);
    check("swap_new_row", int'(rd_row), 8'h03);
    check("done_once",    int'(frame_done), 0);
    read_row(14, v); check("row14", v, 8'h30);
    read_row(0, v);  check("row0",  v, 8'h30);

    // Second frame becomes visible only after its wrap.
    for (int y = 14; y >= 0; y--) step(1'b1, y % 8, y);
    read_row(15, v); check("row15_before_wrap", v, 8'h03);
    step(1'b1, 3, 15);
    step(1'b0, 0, 0);
    read_row(15, v); check("row15_after_wrap", v, 8'h04);
    check("cnt2", int'(frame_cnt), 2);

    // Row skip 10 -> 7 inside a frame.
    for (int y = 14; y >= 10; y--) step(1'b1, 0, y);
    check("no_skip_yet", int'(seq_err), 0);
    step(1'b1, 5, 7);
    check("skip_flag", int'(seq_err), 1);
    for (int y = 6; y >= 0; y--) step(1'b1, 1, y);
    step(1'b1, 0, 15);
    step(1'b0, 0, 0);
    read_row(7, v); check("skipped_pt_stored", v, 8'h20);
    check("skip_sticky", int'(seq_err), 1);

    // Counter wrap: 253 more commits take the count from 3 back to 0.
    top = 15;
    for (int f = 0; f < 253; f++) begin
      scan(top, 1'b0);
      wy = $urandom_range(8, 15);
      rstep(1'b1, $urandom_range(0, 7), wy);
      top = wy;
    end
    check("cnt_wrap", int'(frame_cnt), 0);
    check("skip_sticky2", int'(seq_err), 1);

    // Disable mid-frame: display frozen, strobes ignored.
    for (int y = top; y >= 8; y--) rstep(1'b1, $urandom_range(0, 7), y);
    foreach (snap[i]) snap[i] = m_shown[i];
    cap_en = 1'b0;
    step(1'b1, 4, 15);
    step(1'b1, 5, 3);
    step(1'b1, 6, 14);
    check("off_no_done", int'(frame_done), 0);
    for (int r = 0; r < 16; r++) begin
      read_row(r, v);
      check("off_row_held", v, snap[r]);
    end
    check("off_cnt", int'(frame_cnt), 0);

    // Re-enable: partial frame discarded again, then a normal commit.
    cap_en = 1'b1;
    step(1'b0, 0, 0);
    for (int y = 5; y >= 0; y--) step(1'b1, 7, y);
    step(1'b1, 2, 15);
    step(1'b0, 0, 0);
    check("resync_cnt", int'(frame_cnt), 0);
    scan(15, 1'b0);
    step(1'b1, 0, 15);
    check("resync_commit_cnt", int'(frame_cnt), 1);

    // Randomized frames with random enable drops and random read rows.
    top = 15;
    for (int f = 0; f < 60; f++) begin
      scan(top, 1'b1);
      wy = $urandom_range(8, 15);
      rstep(1'b1, $urandom_range(0, 7), wy);
      top = wy;
    end

    // Reset mid-frame.
    scan(15, 1'b0);
    for (int y = 15; y >= 9; y--) rstep(1'b1, $urandom_range(0, 7), y);
    #2 RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    check("rst_cnt", int'(frame_cnt), 0);
    check("rst_err", int'(seq_err), 0);
    read_row(15, v); check("rst_row15", v, 8'h00);
    repeat (2) step(1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
